pwm_timers: RTL and testbench

//   Timer datapath for one PWM channel; feeds the PWM FSM of the same channel.

---
 rtl/pwm_timers.sv | 99 +++++++++
 tb/tb_pwm_timers.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pwm_timers.sv
// Timer datapath for one PWM channel: shadowed ON/period values, saturating
// down-counters and zero flags for the channel FSM. Optional prescaler: PWM_PRESCALE_EN.
module pwm_timers #(
    parameter int PWM_UNIT       = 0,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      T_on_wr,
    input  logic                      T_period_wr,
    input  logic [COUNTER_WIDTH-1:0]  wr_data,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      dec_T_on,
    input  logic                      dec_T_period,
    input  logic                      reload_times,
    output logic                      T_on_zero,
    output logic                      T_period_zero,
    output logic [COUNTER_WIDTH-1:0]  T_on_count,
    output logic [COUNTER_WIDTH-1:0]  T_period_count,
    output logic                      config_error
);

    localparam int unused_pwm_unit = PWM_UNIT;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = 1;

    // Lane 0 is the ON timer, lane 1 the period timer.
    logic [COUNTER_WIDTH-1:0] shadow_reg [2];
    logic [COUNTER_WIDTH-1:0] count_reg  [2];
    logic                     wr_sel     [2];
    logic                     dec_sel    [2];
    logic                     config_error_reg;
    logic                     tick;

    assign wr_sel[0]  = T_on_wr;
    assign wr_sel[1]  = T_period_wr;
    assign dec_sel[0] = dec_T_on;
    assign dec_sel[1] = dec_T_period;

`ifdef PWM_PRESCALE_EN
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = 1;
    logic [PRESCALE_WIDTH-1:0] prescale_count_reg;

    // >= lets a prescale value lowered mid-cycle still wrap the prescaler to 0.
    assign tick = (prescale_count_reg >= prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_count_reg <= '0;
        end else if (reload_times || tick) begin
            prescale_count_reg <= '0;
        end else begin
            prescale_count_reg <= prescale_count_reg + PRE_ONE;
        end
    end
`else
    logic [PRESCALE_WIDTH-1:0] unused_prescale;
    assign unused_prescale = prescale;
    assign tick            = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    shadow_reg[gi] <= wr_data;
                end
            end

            // Reload wins over decrement; decrement saturates at zero.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count_reg[gi] <= '0;
                end else if (reload_times) begin
                    count_reg[gi] <= shadow_reg[gi];
                end else if (dec_sel[gi] && tick && (count_reg[gi] != '0)) begin
                    count_reg[gi] <= count_reg[gi] - CNT_ONE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            config_error_reg <= 1'b0;
        end else begin
            config_error_reg <= (shadow_reg[0] >= shadow_reg[1]);
        end
    end

    assign T_on_count     = count_reg[0];
    assign T_period_count = count_reg[1];
    assign T_on_zero      = (count_reg[0] == '0);
    assign T_period_zero  = (count_reg[1] == '0);
    assign config_error   = config_error_reg;

endmodule

// File: tb/tb_pwm_timers.sv
// Bench for pwm_timers: directed scenarios plus random traffic, all compared
// against a cycle-level arithmetic model of the timer rules.
module tb_pwm_timers;

    localparam int CW = 32;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          T_on_wr, T_period_wr, dec_T_on, dec_T_period, reload_times;
    logic [CW-1:0] wr_data;
    logic [PW-1:0] prescale;
    logic          T_on_zero, T_period_zero, config_error;
    logic [CW-1:0] T_on_count, T_period_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    longint m_on_sh, m_per_sh, m_on, m_per, m_pre;
    logic   m_cfg;

    pwm_timers #(.PWM_UNIT(0), .COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
        .clk(clk), .reset(reset),
        .T_on_wr(T_on_wr), .T_period_wr(T_period_wr), .wr_data(wr_data),
        .prescale(prescale), .dec_T_on(dec_T_on), .dec_T_period(dec_T_period),
        .reload_times(reload_times), .T_on_zero(T_on_zero), .T_period_zero(T_period_zero),
        .T_on_count(T_on_count), .T_period_count(T_period_count), .config_error(config_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on_sh = 0; m_per_sh = 0; m_on = 0; m_per = 0; m_pre = 0; m_cfg = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".on"},      T_on_count,     CW'(m_on));
        check({tag, ".per"},     T_period_count, CW'(m_per));
        check({tag, ".on_z"},    CW'(T_on_zero),     CW'(m_on == 0));
        check({tag, ".per_z"},   CW'(T_period_zero), CW'(m_per == 0));
        check({tag, ".cfg"},     CW'(config_error),  CW'(m_cfg));
    endtask

    // One clock: drive inputs, advance the model by the timer rules, compare.
    task automatic cycle(input logic won, input logic wper, input logic [CW-1:0] wd,
                         input logic don, input logic dper, input logic rl, input string tag);
        bit tick;
        T_on_wr = won; T_period_wr = wper; wr_data = wd;
        dec_T_on = don; dec_T_period = dper; reload_times = rl;
        @(posedge clk);
`ifdef PWM_PRESCALE_EN
        tick = (m_pre >= longint'(prescale));
`else
        tick = 1'b1;
`endif
        m_cfg = (m_on_sh >= m_per_sh);
        if (rl) begin
            m_on = m_on_sh; m_per = m_per_sh;
        end else begin
            if (don && tick && m_on > 0) m_on = m_on - 1;
            if (dper && tick && m_per > 0) m_per = m_per - 1;
        end
        if (won)  m_on_sh  = longint'(wd);
        if (wper) m_per_sh = longint'(wd);
        m_pre = (rl || tick) ? 0 : m_pre + 1;
        #1;
        $display("cycle %s: wr=%b%b data=%0d dec=%b%b rl=%b -> on=%0d per=%0d cfg=%b",
                 tag, won, wper, wd, don, dper, rl, T_on_count, T_period_count, config_error);
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; prescale = '0; wr_data = '0;
        T_on_wr = 0; T_period_wr = 0; dec_T_on = 0; dec_T_period = 0; reload_times = 0;
        model_reset();
        #1;
        check_all("rst_async");
        #22;
        reset = 1'b1;
        @(posedge clk); #1;

        // Idle after reset
        cycle(0, 0, 0, 0, 0, 0, "idle");
        check("t1_on_zero", CW'(T_on_zero), 1);

        // Load ON=3 / period=10 and reload
        cycle(1, 0, 3, 0, 0, 0, "wr_on3");
        cycle(0, 1, 10, 0, 0, 0, "wr_per10");
        cycle(0, 0, 0, 0, 0, 1, "reload");
        check("t2_on", T_on_count, 3);
        check("t2_per", T_period_count, 10);
        check("t2_cfg", CW'(config_error), 0);

        // Decrement both for 4 cycles, then saturate
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0, "dec");
        check("t3_on", T_on_count, 0);
        check("t3_per", T_period_count, 6);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0, "sat");
        check("t4_on_sat", T_on_count, 0);

        // Write during reload lands in shadow only
        cycle(1, 0, 7, 0, 0, 1, "wr_rl");
        check("t5_old", T_on_count, 3);
        cycle(0, 0, 0, 0, 0, 1, "rl2");
        check("t5_new", T_on_count, 7);

        // config_error follows shadows one cycle later
        cycle(1, 0, 10, 0, 0, 0, "wr_on10");
        cycle(0, 0, 0, 0, 0, 0, "idle_cfg");
        check("t6_cfg_set", CW'(config_error), 1);
        cycle(0, 1, 20, 0, 0, 0, "wr_per20");
        cycle(0, 0, 0, 0, 0, 0, "idle_cfg2");
        check("t6_cfg_clr", CW'(config_error), 0);

`ifdef PWM_PRESCALE_EN
        // Prescale 2: ON counter steps every third cycle
        prescale = 8'd2;
        cycle(1, 0, 2, 0, 0, 0, "wr_on2");
        cycle(0, 0, 0, 1, 0, 1, "rl_pre");
        for (int i = 1; i <= 6; i++) begin
            cycle(0, 0, 0, 1, 0, 0, "pre_dec");
            if (i == 5) check("t7_on_c5", T_on_count, 1);
        end
        check("t7_on_c6", T_on_count, 0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [CW-1:0] wd;
            wd = ($urandom_range(0, 15) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
            prescale = PW'($urandom_range(0, 3));
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), wd,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), "rand");
        end

        // Async reset mid-count
        prescale = '0;
        cycle(1, 0, 5, 0, 0, 0, "wr_on5");
        cycle(0, 0, 0, 0, 0, 1, "rl5");
        cycle(0, 0, 0, 1, 0, 0, "dec5");
        cycle(0, 0, 0, 1, 0, 0, "dec5");
        cycle(0, 0, 0, 1, 0, 0, "dec5");
        check("t8_pre", T_on_count, 2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("t8_on", T_on_count, 0);
        check("t8_on_z", CW'(T_on_zero), 1);
        check_all("t8_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
